// File: rtl/dp_ram_fifo.sv
// FIFO over a simple dual-port RAM whose registered read port doubles as the output stage.
// Valid/ready on both sides, occupancy count, registered almost_full and synchronous flush.
module dp_ram_fifo #(
  parameter int DATA_W = 180,
  parameter int ADDR_W = 6,
  parameter int AF_LVL = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt, ram_cnt_nxt, count_nxt;
  logic              push, pop, fetch, o_valid_nxt;

  // i_ready depends only on registered RAM occupancy, never on o_ready
  assign i_ready = (ram_cnt != DEPTH_C);
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;
  assign fetch   = (ram_cnt != '0) & (~o_valid | o_ready);

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (push & ~fetch)
      ram_cnt_nxt = ram_cnt + CNT_ONE;
    else if (fetch & ~push)
      ram_cnt_nxt = ram_cnt - CNT_ONE;
    o_valid_nxt = fetch | (o_valid & ~pop);
    if (clear) begin
      ram_cnt_nxt = '0;
      o_valid_nxt = 1'b0;
    end
    count_nxt = ram_cnt_nxt + {{ADDR_W{1'b0}}, o_valid_nxt};
  end

  // Control state: pointers, occupancy and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      o_valid     <= 1'b0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PTR_ONE;
        if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      end
      ram_cnt     <= ram_cnt_nxt;
      o_valid     <= o_valid_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_C);
    end
  end

  // RAM port A: write only; contents are never reset
  always_ff @(posedge clk) begin
    if (push & ~clear)
      ram[wr_ptr] <= i_data;
  end

  // RAM port B read register is the output stage; it holds its value on pop and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_data <= '0;
    else if (fetch & ~clear)
      o_data <= ram[rd_ptr];
  end

endmodule

// File: tb/tb_dp_ram_fifo.sv
// Scoreboard bench for dp_ram_fifo: a queue holds every word the FIFO should contain,
// and a small occupancy model tracks RAM entries and the output stage each cycle.
`timescale 1ns/1ps
module tb_dp_ram_fifo;

  localparam int DATA_W = 180;
  localparam int ADDR_W = 6;
  localparam int AF_LVL = 56;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [DATA_W-1:0] i_data = '0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W:0]   count;
  logic              almost_full;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q[$];
  int                m_rc = 0;
  bit                m_ov = 1'b0;

  dp_ram_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LVL(AF_LVL)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] rand_word();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DATA_W-1:0];
  endfunction

  // Advance one clock: update the expected contents from the inputs driven this cycle,
  // then return 1 ns after the edge so outputs are sampled away from it.
  task automatic cycle();
    bit push, pop, fetch;
    @(posedge clk);
    if (rst_n) begin
      push  = i_valid && (m_rc != DEPTH);
      pop   = m_ov && o_ready;
      fetch = (m_rc != 0) && (!m_ov || o_ready);
      if (clear) begin
        q.delete();
        m_rc = 0;
        m_ov = 1'b0;
      end else begin
        if (push) q.push_back(i_data);
        if (pop)  void'(q.pop_front());
        m_rc = m_rc + int'(push) - int'(fetch);
        m_ov = fetch ? 1'b1 : (pop ? 1'b0 : m_ov);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid: got %0b want 0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL reset_o_data: got %0h want 0", o_data); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %0b want 0", almost_full); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready: got %0b want 1", i_ready); end
    rst_n = 1'b1;
    q.delete(); m_rc = 0; m_ov = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] exp;
    i_valid = 1'b1; i_data = DATA_W'(8'hA5); o_ready = 1'b0;
    cycle();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b want 0", o_valid); end
    total++; if (count !== 7'd1) begin bad++; $display("FAIL single_count_ram: got %0d want 1", count); end
    cycle();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", o_valid); end
    total++; if (o_data !== DATA_W'(8'hA5)) begin bad++; $display("FAIL single_data: got %0h want a5", o_data); end
    total++; if (count !== 7'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    exp = q.size() > 0 ? q[0] : '0;
    total++; if (o_data !== exp) begin bad++; $display("FAIL single_sb: got %0h want %0h", o_data, exp); end
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", count); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %0b want 0", o_valid); end
  endtask

  task automatic test_full();
    int drained;
    o_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      i_valid = 1'b1; i_data = DATA_W'(i);
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    total++; if (count !== 7'(DEPTH + 1)) begin bad++; $display("FAIL full_count: got %0d want %0d", count, DEPTH + 1); end
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL full_i_ready: got %0b want 0", i_ready); end
    i_valid = 1'b1; i_data = DATA_W'(999);
    cycle();
    i_valid = 1'b0;
    total++; if (count !== 7'(DEPTH + 1)) begin bad++; $display("FAIL full_overflow_count: got %0d want %0d", count, DEPTH + 1); end
    o_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 200 && drained < DEPTH + 1 + 1; c++) begin
      if (o_valid === 1'b1) begin
        total++;
        if (o_data !== DATA_W'(drained)) begin
          bad++; $display("FAIL full_drain_order: got %0d want %0d", o_data, drained);
        end
        drained++;
      end
      cycle();
    end
    o_ready = 1'b0;
    total++; if (drained != DEPTH + 1) begin bad++; $display("FAIL full_drain_total: got %0d want %0d", drained, DEPTH + 1); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL full_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    bit started;
    int steady;
    logic [DATA_W-1:0] exp;
    started = 1'b0; steady = -1;
    i_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      i_data = rand_word();
      if (started) begin
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble: cycle %0d o_valid=%0b want 1", c, o_valid); end
      end
      if (o_valid === 1'b1) begin
        started = 1'b1;
        exp = q.size() > 0 ? q[0] : '0;
        total++; if (o_data !== exp) begin bad++; $display("FAIL b2b_data: got %0h want %0h", o_data, exp); end
      end
      total++; if (count !== 7'(m_rc + int'(m_ov))) begin bad++; $display("FAIL b2b_count: got %0d want %0d", count, m_rc + int'(m_ov)); end
      if (c == 10) steady = int'(count);
      if (c > 10) begin
        total++; if (int'(count) != steady) begin bad++; $display("FAIL b2b_count_const: got %0d want %0d", count, steady); end
      end
      cycle();
    end
    i_valid = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    o_ready = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL b2b_empty: got %0d want 0", count); end
  endtask

  task automatic test_random();
    int pushed;
    logic [DATA_W-1:0] exp;
    pushed = 0;
    for (int c = 0; c < 60000 && pushed < 10000; c++) begin
      i_valid = ($urandom_range(1) == 1);
      o_ready = ($urandom_range(1) == 1);
      i_data  = rand_word();
      if (i_valid && m_rc != DEPTH) pushed++;
      total++; if (count !== 7'(m_rc + int'(m_ov))) begin bad++; $display("FAIL rand_count: got %0d want %0d", count, m_rc + int'(m_ov)); end
      if (o_valid !== m_ov) begin total++; bad++; $display("FAIL rand_valid: got %0b want %0b", o_valid, m_ov); end
      if (o_valid === 1'b1 && o_ready) begin
        exp = q.size() > 0 ? q[0] : '0;
        total++; if (o_data !== exp) begin bad++; $display("FAIL rand_data: got %0h want %0h", o_data, exp); end
      end
      cycle();
    end
    total++; if (pushed < 10000) begin bad++; $display("FAIL rand_budget: pushed %0d want 10000", pushed); end
    i_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 150 && (m_ov || m_rc != 0); c++) begin
      if (o_valid === 1'b1) begin
        exp = q.size() > 0 ? q[0] : '0;
        total++; if (o_data !== exp) begin bad++; $display("FAIL rand_drain: got %0h want %0h", o_data, exp); end
      end
      cycle();
    end
    o_ready = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL rand_end_count: got %0d want 0", count); end
  endtask

  task automatic test_clear();
    logic [DATA_W-1:0] held;
    o_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      i_valid = 1'b1; i_data = DATA_W'(i + 100);
      cycle();
    end
    total++; if (count !== 7'd40) begin bad++; $display("FAIL clear_fill: got %0d want 40", count); end
    held = o_data;
    clear = 1'b1; i_valid = 1'b1; o_ready = 1'b1; i_data = DATA_W'(16'hDEAD);
    cycle();
    clear = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL clear_count: got %0d want 0", count); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL clear_valid: got %0b want 0", o_valid); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL clear_i_ready: got %0b want 1", i_ready); end
    total++; if (o_data !== held) begin bad++; $display("FAIL clear_o_data_held: got %0h want %0h", o_data, held); end
    i_valid = 1'b1; i_data = DATA_W'(8'h77);
    cycle();
    i_valid = 1'b0;
    cycle();
    total++; if (o_data !== DATA_W'(8'h77)) begin bad++; $display("FAIL clear_next_word: got %0h want 77", o_data); end
    total++; if (count !== 7'd1) begin bad++; $display("FAIL clear_next_count: got %0d want 1", count); end
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL clear_drain: got %0d want 0", count); end
  endtask

  task automatic test_almost_full();
    o_ready = 1'b0;
    for (int i = 0; i < AF_LVL - 1; i++) begin
      i_valid = 1'b1; i_data = DATA_W'(i);
      cycle();
    end
    i_valid = 1'b0;
    total++; if (count !== 7'(AF_LVL - 1)) begin bad++; $display("FAIL af_count55: got %0d want %0d", count, AF_LVL - 1); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_below: got %0b want 0", almost_full); end
    i_valid = 1'b1; i_data = DATA_W'(AF_LVL - 1);
    cycle();
    i_valid = 1'b0;
    total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL af_at: got %0b want 1", almost_full); end
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_after_pop: got %0b want 0", almost_full); end
  endtask

  task automatic test_reset_mid();
    i_valid = 1'b1; o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_data = DATA_W'(i + 1);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL rstmid_data: got %0h want 0", o_data); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rstmid_af: got %0b want 0", almost_full); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rstmid_i_ready: got %0b want 1", i_ready); end
    i_valid = 1'b0;
    q.delete(); m_rc = 0; m_ov = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    total++; if (count !== 7'd0) begin bad++; $display("FAIL rstmid_after: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_clear();
    test_almost_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
